// File: rtl/axi_lite_addr_router_if.sv
// Request-side routing bundle between the AXI-Lite master, the response muxes and the router.
// Latency: none, this is a signal bundle only.
// Backpressure: readies/valids arrive from the response mux; the router gates master valids only.
// Ports: m_* master/response-mux handshakes and addresses; wsel/rsel mux selects;
//        s_awvalid/s_wvalid/s_arvalid one-hot per-slave valids; err_wcnt/err_rcnt decode-error counts.
interface axi_lite_addr_router_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic                  m_awvalid;
    logic                  m_awready;
    logic                  m_wvalid;
    logic                  m_wready;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic                  m_arvalid;
    logic                  m_arready;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [2:0]            wsel;
    logic [2:0]            rsel;
    logic [5:0]            s_awvalid;
    logic [5:0]            s_wvalid;
    logic [5:0]            s_arvalid;
    logic [7:0]            err_wcnt;
    logic [7:0]            err_rcnt;

    // Master side: the AXI-Lite master plus the response muxes feeding the router.
    modport master (
        output m_awaddr, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready,
        output m_araddr, m_arvalid, m_arready, m_rvalid, m_rready,
        input  wsel, rsel, s_awvalid, s_wvalid, s_arvalid, err_wcnt, err_rcnt
    );

    // Slave side: the router itself.
    modport slave (
        input  m_awaddr, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready,
        input  m_araddr, m_arvalid, m_arready, m_rvalid, m_rready,
        output wsel, rsel, s_awvalid, s_wvalid, s_arvalid, err_wcnt, err_rcnt
    );
endinterface

// File: rtl/axi_lite_addr_router.sv
// AXI-Lite 1:6 request router: decodes AW/AR address top bits, steers master valids one-hot, holds mux selects.
// Latency: 1 cycle decode (select registered on the valid edge); slave valids are combinational afterwards.
// Backpressure: none added; each phase advances only on the master valid/ready handshake from the response mux.
// Ports: aclk, aresetn (async active-low); bus = slave modport of axi_lite_addr_router_if.
module axi_lite_addr_router #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axi_lite_addr_router_if.slave   bus
);
    localparam logic [2:0] SEL_ERR  = 3'b110;
    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e   w_state_q, w_state_d;
    r_state_e   r_state_q, r_state_d;
    logic [2:0] wsel_q, wsel_d;
    logic [2:0] rsel_q, rsel_d;
    logic [7:0] err_wcnt_q, err_wcnt_d;
    logic [7:0] err_rcnt_q, err_rcnt_d;
    logic       aw_gate, w_gate, ar_gate;
    logic [5:0] s_awvalid, s_wvalid, s_arvalid;

    // Indices 6 and 7 have no slave behind them and go to the error slot.
    function automatic logic [2:0] decode(input logic [2:0] idx);
        return (idx >= 3'd6) ? SEL_ERR : idx;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            wsel_q     <= SEL_IDLE;
            rsel_q     <= SEL_IDLE;
            err_wcnt_q <= 8'd0;
            err_rcnt_q <= 8'd0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            err_wcnt_q <= err_wcnt_d;
            err_rcnt_q <= err_rcnt_d;
        end
    end

    // Write channel
    always_comb begin
        w_state_d  = w_state_q;
        wsel_d     = wsel_q;
        err_wcnt_d = err_wcnt_q;
        aw_gate    = 1'b0;
        w_gate     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (bus.m_awvalid) begin
                    wsel_d    = decode(bus.m_awaddr[ADDR_WIDTH-1 -: 3]);
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                aw_gate = 1'b1;
                if (bus.m_awvalid && bus.m_awready) begin
                    w_state_d = W_DATA;
                    if (wsel_q == SEL_ERR && err_wcnt_q != 8'hFF) begin
                        err_wcnt_d = err_wcnt_q + 8'd1;
                    end
                end
            end
            W_DATA: begin
                w_gate = 1'b1;
                if (bus.m_wvalid && bus.m_wready) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                // Select stays live through the B handshake edge, then parks at idle.
                if (bus.m_bvalid && bus.m_bready) begin
                    w_state_d = W_IDLE;
                    wsel_d    = SEL_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                wsel_d    = SEL_IDLE;
            end
        endcase
    end

    // Read channel
    always_comb begin
        r_state_d  = r_state_q;
        rsel_d     = rsel_q;
        err_rcnt_d = err_rcnt_q;
        ar_gate    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (bus.m_arvalid) begin
                    rsel_d    = decode(bus.m_araddr[ADDR_WIDTH-1 -: 3]);
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                ar_gate = 1'b1;
                if (bus.m_arvalid && bus.m_arready) begin
                    r_state_d = R_DATA;
                    if (rsel_q == SEL_ERR && err_rcnt_q != 8'hFF) begin
                        err_rcnt_d = err_rcnt_q + 8'd1;
                    end
                end
            end
            R_DATA: begin
                if (bus.m_rvalid && bus.m_rready) begin
                    r_state_d = R_IDLE;
                    rsel_d    = SEL_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rsel_d    = SEL_IDLE;
            end
        endcase
    end

    // Error and idle codes match no slave index, so they never raise a slave valid.
    always_comb begin
        s_awvalid = 6'b0;
        s_wvalid  = 6'b0;
        s_arvalid = 6'b0;
        for (int i = 0; i < 6; i++) begin
            s_awvalid[i] = aw_gate && bus.m_awvalid && (wsel_q == 3'(i));
            s_wvalid[i]  = w_gate  && bus.m_wvalid  && (wsel_q == 3'(i));
            s_arvalid[i] = ar_gate && bus.m_arvalid && (rsel_q == 3'(i));
        end
    end

    assign bus.wsel      = wsel_q;
    assign bus.rsel      = rsel_q;
    assign bus.s_awvalid = s_awvalid;
    assign bus.s_wvalid  = s_wvalid;
    assign bus.s_arvalid = s_arvalid;
    assign bus.err_wcnt  = err_wcnt_q;
    assign bus.err_rcnt  = err_rcnt_q;
endmodule

// File: tb/tb_axi_lite_addr_router.sv
// Bench for axi_lite_addr_router: transaction-level master tasks, a response-mux model and random slave readies.
// Latency: checks decode on the edge after valid and per-phase cycle counts.
// Backpressure: slave readies/valids randomised or forced per scenario.
module tb_axi_lite_addr_router;
    localparam int BUDGET = 200;

    logic aclk;
    logic aresetn;
    int   checks   = 0;
    int   failures = 0;
    int   exp_werr = 0;
    int   exp_rerr = 0;
    bit   rand_en  = 0;

    logic [5:0] slv_awready, slv_wready, slv_bvalid, slv_arready, slv_rvalid;

    axi_lite_addr_router_if #(.ADDR_WIDTH(32)) bus ();

    axi_lite_addr_router #(.ADDR_WIDTH(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Response mux model: idle returns zeros, error slot returns ready/valid = 1, else the selected slave.
    function automatic logic pick(input logic [2:0] sel, input logic [5:0] v);
        if (sel == 3'b111) return 1'b0;
        if (sel == 3'b110) return 1'b1;
        return v[sel];
    endfunction

    assign bus.m_awready = pick(bus.wsel, slv_awready);
    assign bus.m_wready  = pick(bus.wsel, slv_wready);
    assign bus.m_bvalid  = pick(bus.wsel, slv_bvalid);
    assign bus.m_arready = pick(bus.rsel, slv_arready);
    assign bus.m_rvalid  = pick(bus.rsel, slv_rvalid);

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_en) begin
                slv_awready = 6'($urandom);
                slv_wready  = 6'($urandom);
                slv_bvalid  = 6'($urandom);
                slv_arready = 6'($urandom);
                slv_rvalid  = 6'($urandom);
            end
        end
    end

    // Reference: each 512 MiB region is one slave; regions 6 and 7 are unmapped.
    function automatic logic [2:0] exp_slot(input logic [31:0] a);
        int idx;
        idx = int'(a / 32'h2000_0000);
        return (idx >= 6) ? 3'd6 : 3'(idx);
    endfunction

    function automatic logic [5:0] exp_onehot(input logic [2:0] s);
        return (s < 3'd6) ? 6'(1 << s) : 6'b0;
    endfunction

    function automatic logic [7:0] sat(input int n);
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    task automatic timeout_abort(input string name);
        failures++;
        $display("FAIL %s: no handshake within %0d cycles", name, BUDGET);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "handshake timeout");
    endtask

    task automatic all_ready();
        rand_en     = 0;
        slv_awready = 6'h3F;
        slv_wready  = 6'h3F;
        slv_bvalid  = 6'h3F;
        slv_arready = 6'h3F;
        slv_rvalid  = 6'h3F;
    endtask

    // Called #1 after a rising edge with the write channel idle; returns #1 after the B handshake edge.
    task automatic do_write(input logic [31:0] addr, input bit change_addr,
                            output int n_aw, output int n_w, output int n_b);
        logic [2:0] es;
        logic [5:0] oh;
        bit         hs;
        es = exp_slot(addr);
        oh = exp_onehot(es);
        n_aw = 0; n_w = 0; n_b = 0;
        bus.m_awaddr  = addr;
        bus.m_awvalid = 1'b1;
        bus.m_wvalid  = 1'b1;
        @(negedge aclk);
        checks++;
        if (bus.wsel !== 3'b111 || bus.s_awvalid !== 6'b0) begin
            failures++;
            $display("FAIL wr_idle: wsel=%0d s_awvalid=%b, required wsel=7 s_awvalid=0", bus.wsel, bus.s_awvalid);
        end
        @(posedge aclk); #1;
        hs = 0;
        while (!hs && n_aw < BUDGET) begin
            @(negedge aclk); n_aw++;
            checks++;
            if (bus.wsel !== es || bus.s_awvalid !== oh || bus.s_wvalid !== 6'b0) begin
                failures++;
                $display("FAIL wr_aw_phase: wsel=%0d aw=%b w=%b, required wsel=%0d aw=%b w=000000",
                         bus.wsel, bus.s_awvalid, bus.s_wvalid, es, oh);
            end
            hs = bus.m_awready;
            @(posedge aclk); #1;
        end
        if (!hs) timeout_abort("wr_aw_timeout");
        bus.m_awvalid = 1'b0;
        if (change_addr) bus.m_awaddr = $urandom;
        if (es == 3'd6) exp_werr++;
        hs = 0;
        while (!hs && n_w < BUDGET) begin
            @(negedge aclk); n_w++;
            checks++;
            if (bus.wsel !== es || bus.s_awvalid !== 6'b0 || bus.s_wvalid !== oh) begin
                failures++;
                $display("FAIL wr_w_phase: wsel=%0d aw=%b w=%b, required wsel=%0d aw=000000 w=%b",
                         bus.wsel, bus.s_awvalid, bus.s_wvalid, es, oh);
            end
            hs = bus.m_wready;
            @(posedge aclk); #1;
        end
        if (!hs) timeout_abort("wr_w_timeout");
        bus.m_wvalid = 1'b0;
        bus.m_bready = 1'b1;
        hs = 0;
        while (!hs && n_b < BUDGET) begin
            @(negedge aclk); n_b++;
            checks++;
            if (bus.wsel !== es || bus.s_awvalid !== 6'b0 || bus.s_wvalid !== 6'b0) begin
                failures++;
                $display("FAIL wr_b_phase: wsel=%0d aw=%b w=%b, required wsel=%0d and no valids",
                         bus.wsel, bus.s_awvalid, bus.s_wvalid, es);
            end
            hs = bus.m_bvalid;
            @(posedge aclk); #1;
        end
        if (!hs) timeout_abort("wr_b_timeout");
        bus.m_bready = 1'b0;
        checks++;
        if (bus.wsel !== 3'b111) begin
            failures++;
            $display("FAIL wr_release: wsel=%0d, required 7", bus.wsel);
        end
        checks++;
        if (bus.err_wcnt !== sat(exp_werr)) begin
            failures++;
            $display("FAIL wr_errcnt: err_wcnt=%0d, required %0d", bus.err_wcnt, sat(exp_werr));
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output int n_ar, output int n_r);
        logic [2:0] es;
        logic [5:0] oh;
        bit         hs;
        es = exp_slot(addr);
        oh = exp_onehot(es);
        n_ar = 0; n_r = 0;
        bus.m_araddr  = addr;
        bus.m_arvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if (bus.rsel !== 3'b111 || bus.s_arvalid !== 6'b0) begin
            failures++;
            $display("FAIL rd_idle: rsel=%0d s_arvalid=%b, required rsel=7 s_arvalid=0", bus.rsel, bus.s_arvalid);
        end
        @(posedge aclk); #1;
        hs = 0;
        while (!hs && n_ar < BUDGET) begin
            @(negedge aclk); n_ar++;
            checks++;
            if (bus.rsel !== es || bus.s_arvalid !== oh) begin
                failures++;
                $display("FAIL rd_ar_phase: rsel=%0d ar=%b, required rsel=%0d ar=%b", bus.rsel, bus.s_arvalid, es, oh);
            end
            hs = bus.m_arready;
            @(posedge aclk); #1;
        end
        if (!hs) timeout_abort("rd_ar_timeout");
        bus.m_arvalid = 1'b0;
        bus.m_araddr  = $urandom;
        bus.m_rready  = 1'b1;
        if (es == 3'd6) exp_rerr++;
        hs = 0;
        while (!hs && n_r < BUDGET) begin
            @(negedge aclk); n_r++;
            checks++;
            if (bus.rsel !== es || bus.s_arvalid !== 6'b0) begin
                failures++;
                $display("FAIL rd_r_phase: rsel=%0d ar=%b, required rsel=%0d ar=000000", bus.rsel, bus.s_arvalid, es);
            end
            hs = bus.m_rvalid;
            @(posedge aclk); #1;
        end
        if (!hs) timeout_abort("rd_r_timeout");
        bus.m_rready = 1'b0;
        checks++;
        if (bus.rsel !== 3'b111) begin
            failures++;
            $display("FAIL rd_release: rsel=%0d, required 7", bus.rsel);
        end
        checks++;
        if (bus.err_rcnt !== sat(exp_rerr)) begin
            failures++;
            $display("FAIL rd_errcnt: err_rcnt=%0d, required %0d", bus.err_rcnt, sat(exp_rerr));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.wsel !== 3'b111 || bus.rsel !== 3'b111 || bus.s_awvalid !== 6'b0 || bus.s_wvalid !== 6'b0 ||
            bus.s_arvalid !== 6'b0 || bus.err_wcnt !== 8'd0 || bus.err_rcnt !== 8'd0) begin
            failures++;
            $display("FAIL %s: wsel=%0d rsel=%0d aw=%b w=%b ar=%b ewc=%0d erc=%0d, required 7 7 0 0 0 0 0",
                     name, bus.wsel, bus.rsel, bus.s_awvalid, bus.s_wvalid, bus.s_arvalid, bus.err_wcnt, bus.err_rcnt);
        end
    endtask

    task automatic check_cycles(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: cycles=%0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("reset_state");
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_write_slave2();
        int a, w, b;
        all_ready();
        do_write(32'h4000_0010, 1'b0, a, w, b);
        check_cycles("wr_min_aw", a, 1);
        check_cycles("wr_min_w", w, 1);
        check_cycles("wr_min_b", b, 1);
    endtask

    task automatic test_read_unmapped();
        int a, r;
        all_ready();
        do_read(32'hE000_0000, a, r);
        check_cycles("rd_min_ar", a, 1);
        check_cycles("rd_min_r", r, 1);
    endtask

    task automatic test_concurrent();
        int a, w, b, ar, r;
        all_ready();
        fork
            do_write(32'h0000_0100, 1'b0, a, w, b);
            do_read(32'hA000_0200, ar, r);
        join
    endtask

    task automatic test_aw_stall();
        int a, w, b;
        all_ready();
        slv_awready[3] = 1'b0;
        fork
            do_write(32'h6000_0040, 1'b1, a, w, b);
            begin
                repeat (6) @(posedge aclk);
                #1 slv_awready[3] = 1'b1;
            end
        join
        check_cycles("aw_stall_cycles", a, 6);
    endtask

    task automatic test_back_to_back();
        int a, w, b, ar, r;
        rand_en = 1;
        do_write(32'h2000_0000, 1'b0, a, w, b);
        do_write(32'hC000_0000, 1'b0, a, w, b);
        do_write(32'h8000_0004, 1'b1, a, w, b);
        do_read(32'h3FFF_FFFC, ar, r);
        do_read(32'hFFFF_FFFF, ar, r);
    endtask

    task automatic test_random();
        int a, w, b, ar, r;
        rand_en = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: do_write($urandom, 1'($urandom), a, w, b);
                1: do_read($urandom, ar, r);
                default: fork
                    do_write($urandom, 1'($urandom), a, w, b);
                    do_read($urandom, ar, r);
                join
            endcase
        end
    endtask

    task automatic test_err_saturation();
        int ar, r;
        all_ready();
        for (int i = 0; i < 300; i++) begin
            do_read(32'hE000_0000 | 32'($urandom_range(0, 32'h1FFF_FFFF)), ar, r);
        end
        checks++;
        if (bus.err_rcnt !== 8'hFF) begin
            failures++;
            $display("FAIL err_rcnt_sat: err_rcnt=%0d, required 255", bus.err_rcnt);
        end
    endtask

    task automatic test_reset_mid_write();
        int a, w, b;
        all_ready();
        slv_wready = 6'b0;
        bus.m_awaddr  = 32'h2000_0008;
        bus.m_awvalid = 1'b1;
        bus.m_wvalid  = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        bus.m_awvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.s_wvalid !== 6'b000010) begin
            failures++;
            $display("FAIL mid_w_phase: s_wvalid=%b, required 000010", bus.s_wvalid);
        end
        #2 aresetn = 1'b0;
        exp_werr = 0;
        exp_rerr = 0;
        #1;
        check_reset_outputs("reset_async_mid_w");
        bus.m_wvalid = 1'b0;
        slv_wready   = 6'h3F;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        do_write(32'h8000_0000, 1'b0, a, w, b);
        check_cycles("post_reset_aw", a, 1);
    endtask

    initial begin
        aresetn       = 1'b0;
        bus.m_awaddr  = 32'h0;
        bus.m_awvalid = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;
        bus.m_araddr  = 32'h0;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;
        all_ready();
        test_reset();
        test_write_slave2();
        test_read_unmapped();
        test_concurrent();
        test_aw_stall();
        test_back_to_back();
        test_random();
        test_err_saturation();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
